// File: rtl/cu_branch_sequencer_if.sv
// Sequencer-facing bundle: control inputs, microcode ROM fields and sequencer status.
// Purely combinational wiring; no latency, no backpressure of its own.
interface cu_branch_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              stall;
    logic              z_in;
    logic              z_load;
    logic [1:0]        cond_sel;
    logic [ADDR_W-1:0] br_target;
    logic              halt;
    logic [ADDR_W-1:0] upc;
    logic              running;
    logic              taken;
    logic              z_flag;
    logic              done;
    logic [15:0]       branch_cnt;

    modport master (
        output start, stall, z_in, z_load, cond_sel, br_target, halt,
        input  upc, running, taken, z_flag, done, branch_cnt
    );

    modport slave (
        input  start, stall, z_in, z_load, cond_sel, br_target, halt,
        output upc, running, taken, z_flag, done, branch_cnt
    );
endinterface

// File: rtl/cu_branch_sequencer.sv
// Micro-program sequencer: owns the micro-PC, zero flag and taken-branch counter.
// Latency: one microinstruction commits per unstalled RUN cycle; done pulses one edge after END.
// Backpressure: stall freezes upc, z_flag and branch_cnt; start is honoured only when idle.
module cu_branch_sequencer #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cu_branch_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic              z_flag_q, z_flag_d;
    logic [15:0]       branch_cnt_q, branch_cnt_d;
    logic              taken;

    // Branch decision always looks at the registered flag, never the live ALU result.
    always_comb begin
        taken = 1'b0;
        if (state_q == ST_RUN) begin
            case (bus.cond_sel)
                2'd1:    taken = z_flag_q;
                2'd2:    taken = ~z_flag_q;
                2'd3:    taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        upc_d        = upc_q;
        z_flag_d     = z_flag_q;
        branch_cnt_d = branch_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_RUN;
                    upc_d        = START_ADDR;
                    z_flag_d     = 1'b0;
                    branch_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    if (bus.z_load) begin
                        z_flag_d = bus.z_in;
                    end
                    // END wins over any branch encoding; upc keeps the END address.
                    if (bus.halt) begin
                        state_d = ST_DONE;
                    end else if (taken) begin
                        upc_d = bus.br_target;
                        if (branch_cnt_q != 16'hFFFF) begin
                            branch_cnt_d = branch_cnt_q + 16'd1;
                        end
                    end else begin
                        upc_d = upc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            upc_q        <= START_ADDR;
            z_flag_q     <= 1'b0;
            branch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            upc_q        <= upc_d;
            z_flag_q     <= z_flag_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign bus.upc        = upc_q;
    assign bus.running    = (state_q == ST_RUN);
    assign bus.taken      = taken;
    assign bus.z_flag     = z_flag_q;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.branch_cnt = branch_cnt_q;

endmodule

// File: tb/tb_cu_branch_sequencer.sv
// Directed walk through the sequencer's scenarios, then random traffic, against a behavioural model.
module tb_cu_branch_sequencer;

    logic clk;
    logic rst_n;

    cu_branch_sequencer_if #(.ADDR_W(8)) bus ();

    cu_branch_sequencer #(
        .ADDR_W     (8),
        .START_ADDR (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: a "program is executing" flag, a "finished" flag and plain counters.
    bit m_run;
    bit m_fin;
    bit m_z;
    int m_upc;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("upc",        {24'd0, bus.upc},        m_upc);
        chk("running",    {31'd0, bus.running},    {31'd0, m_run});
        chk("z_flag",     {31'd0, bus.z_flag},     {31'd0, m_z});
        chk("done",       {31'd0, bus.done},       {31'd0, m_fin});
        chk("branch_cnt", {16'd0, bus.branch_cnt}, m_cnt);
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_fin = 1'b0;
        m_z   = 1'b0;
        m_upc = 0;
        m_cnt = 0;
    endtask

    // One microinstruction cycle: drive inputs, check taken, clock, then check the state.
    task automatic step(input bit st, input bit stl, input bit zi, input bit zl,
                        input bit [1:0] cs, input bit [7:0] bt, input bit h);
        bit exp_taken;
        bus.start     = st;
        bus.stall     = stl;
        bus.z_in      = zi;
        bus.z_load    = zl;
        bus.cond_sel  = cs;
        bus.br_target = bt;
        bus.halt      = h;
        #1;
        exp_taken = m_run && ((cs == 2'd3) || (cs == 2'd1 && m_z) || (cs == 2'd2 && !m_z));
        chk("taken", {31'd0, bus.taken}, {31'd0, exp_taken});
        @(posedge clk);
        if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_run) begin
            if (!stl) begin
                if (zl) m_z = zi;
                if (h) begin
                    m_run = 1'b0;
                    m_fin = 1'b1;
                end else if (exp_taken) begin
                    m_upc = bt;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end else begin
                    m_upc = (m_upc + 1) % 256;
                end
            end
        end else if (st) begin
            m_run = 1'b1;
            m_upc = 0;
            m_z   = 1'b0;
            m_cnt = 0;
        end
        #1;
        check_all();
    endtask

    initial begin
        bus.start = 0; bus.stall = 0; bus.z_in = 0; bus.z_load = 0;
        bus.cond_sel = 0; bus.br_target = 0; bus.halt = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("taken_rst", {31'd0, bus.taken}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // start, then straight-line increments 0,1,2,3
        step(1, 0, 0, 0, 2'd0, 8'h00, 0);
        step(0, 0, 0, 0, 2'd0, 8'h00, 0);
        step(0, 0, 0, 0, 2'd0, 8'h00, 0);
        step(0, 0, 0, 0, 2'd0, 8'h00, 0);
        // flag load and branch in the same commit: old flag decides
        step(0, 0, 1, 1, 2'd1, 8'h20, 0);
        step(0, 0, 0, 0, 2'd1, 8'h40, 0);
        step(0, 0, 0, 0, 2'd2, 8'h77, 0);
        step(0, 0, 0, 1, 2'd0, 8'h00, 0);
        step(0, 0, 0, 0, 2'd2, 8'h10, 0);
        // stalled cycles ignore z_load and hold everything
        step(0, 1, 1, 1, 2'd3, 8'h99, 0);
        step(0, 1, 1, 1, 2'd3, 8'h99, 0);
        step(0, 1, 1, 1, 2'd3, 8'h99, 0);
        step(0, 0, 0, 0, 2'd0, 8'h00, 0);
        // wrap from 0xFF to 0x00
        step(0, 0, 0, 0, 2'd3, 8'hFF, 0);
        step(0, 0, 0, 0, 2'd0, 8'h00, 0);
        step(0, 0, 0, 0, 2'd3, 8'h05, 0);
        // END with an unconditional-branch encoding, start during DONE ignored
        step(0, 0, 0, 0, 2'd3, 8'h80, 1);
        step(1, 0, 0, 0, 2'd0, 8'h00, 0);
        step(0, 1, 0, 0, 2'd3, 8'h12, 0);
        // run to 0x33, then asynchronous reset between edges
        step(1, 0, 0, 0, 2'd0, 8'h00, 0);
        step(0, 0, 0, 0, 2'd3, 8'h33, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_upc",     {24'd0, bus.upc},     32'd0);
        chk("async_running", {31'd0, bus.running}, 32'd0);
        chk("async_done",    {31'd0, bus.done},    32'd0);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 2'd0, 8'h00, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom),
                 1'($urandom),
                 2'($urandom),
                 8'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
